// File: rtl/panda_mem_arbiter.sv
// ---------------------------------------------------------------------------
// panda_mem_arbiter
//
// Shares a single memory request channel between an instruction fetch port
// and a load/store port. Picks a requester combinationally, alternates
// round-robin when both are requesting, and holds the choice while the
// memory stalls a request. The owner of every accepted request goes into an
// in-order FIFO so that each response is routed back to the right port.
//
// Parameters
//   MaxOutstanding : accepted transactions that may await a response (1..4)
//
// Ports
//   clk_i, rst_ni                     : clock, async active-low reset
//   instr_req_i / instr_addr_i        : fetch request
//   instr_gnt_o                       : fetch request accepted this cycle
//   instr_rvalid_o / instr_rdata_o    : fetch response
//   data_req_i/we/be/addr/wdata       : LSU request
//   data_gnt_o                        : LSU request accepted this cycle
//   data_rvalid_o / data_rdata_o      : LSU response
//   mem_req_o/we/be/addr/wdata        : shared memory request channel
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i : memory grant and response
//   outstanding_o                     : responses still awaited
//   err_o                             : sticky, response with nothing owed
// ---------------------------------------------------------------------------
module panda_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,

  output logic [2:0]  outstanding_o,
  output logic        err_o
);

  localparam logic [2:0] FULL_CNT = 3'(MaxOutstanding);
  localparam logic [1:0] LAST_PTR = 2'(MaxOutstanding - 1);

  // Owner encoding used throughout: 0 = instruction port, 1 = data port.
  localparam logic OWNER_INSTR = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  // Lock state: a request was presented but not yet granted, so the
  // selection must stay on the same requester.
  typedef enum logic [1:0] {
    ARB_FREE       = 2'd0,
    ARB_HOLD_INSTR = 2'd1,
    ARB_HOLD_DATA  = 2'd2
  } arb_state_e;

  arb_state_e r_state;
  arb_state_e w_state_next;

  // Response-order FIFO. Storage is sized for the largest legal depth so the
  // 2-bit pointers index it exactly; only the first MaxOutstanding entries
  // are ever used because the pointers wrap at LAST_PTR.
  logic       r_owner [4];
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_count;
  logic       r_rr_data;   // 1: data port wins the next tie
  logic       r_err;

  logic       w_empty;
  logic       w_full;
  logic       w_slot_ok;
  logic       w_sel;
  logic       w_sel_req;
  logic       w_mem_req;
  logic       w_hs;
  logic       w_pop;
  logic       w_head;
  logic       w_spurious;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  // -------------------------------------------------------------------------
  // Requester selection and handshake
  // -------------------------------------------------------------------------
  always_comb begin
    w_empty    = (r_count == 3'd0);
    w_full     = (r_count == FULL_CNT);
    // A response arriving this cycle frees a slot for a same-cycle push.
    w_slot_ok  = !w_full || mem_rvalid_i;

    w_sel = OWNER_INSTR;
    unique case (r_state)
      ARB_HOLD_INSTR: w_sel = OWNER_INSTR;
      ARB_HOLD_DATA:  w_sel = OWNER_DATA;
      default: begin
        if (instr_req_i && data_req_i) w_sel = r_rr_data;
        else                           w_sel = data_req_i;
      end
    endcase

    w_sel_req  = w_sel ? data_req_i : instr_req_i;
    // rst_ni gating keeps every handshake output low while reset is held,
    // independent of what the requesters are driving.
    w_mem_req  = rst_ni && w_sel_req && w_slot_ok;
    w_hs       = w_mem_req && mem_gnt_i;

    w_head     = r_owner[r_rptr];
    w_pop      = rst_ni && mem_rvalid_i && !w_empty;
    w_spurious = mem_rvalid_i && w_empty;
  end

  // -------------------------------------------------------------------------
  // Lock state machine
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = ARB_FREE;
    if (w_mem_req && !mem_gnt_i) begin
      w_state_next = w_sel ? ARB_HOLD_DATA : ARB_HOLD_INSTR;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ARB_FREE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin pointer, FIFO control and error flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_data <= 1'b1;
      r_wptr    <= 2'd0;
      r_rptr    <= 2'd0;
      r_count   <= 3'd0;
      r_err     <= 1'b0;
    end else begin
      if (w_hs) begin
        r_rr_data <= ~w_sel;
        r_wptr    <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      unique case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_spurious) begin
        r_err <= 1'b1;
      end
    end
  end

  // Owner storage carries no reset: entries are only read behind r_count.
  always_ff @(posedge clk_i) begin
    if (w_hs) begin
      r_owner[r_wptr] <= w_sel;
    end
  end

  // -------------------------------------------------------------------------
  // Output drive
  // -------------------------------------------------------------------------
  always_comb begin
    mem_req_o = w_mem_req;
    if (w_sel == OWNER_DATA) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else begin
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_addr_o  = instr_addr_i;
      mem_wdata_o = 32'd0;
    end

    instr_gnt_o    = w_hs && (w_sel == OWNER_INSTR);
    data_gnt_o     = w_hs && (w_sel == OWNER_DATA);
    instr_rvalid_o = w_pop && (w_head == OWNER_INSTR);
    data_rvalid_o  = w_pop && (w_head == OWNER_DATA);
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    outstanding_o  = r_count;
    err_o          = r_err;
  end

endmodule

// File: tb/tb_panda_mem_arbiter.sv
module tb_panda_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  panda_mem_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_i  = 1'b0;
    instr_addr_i = 32'h0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
  endtask

  task automatic chk_gnt(input string tag, input logic ig, input logic dg);
    chk({tag, "_igtn"}, 32'(instr_gnt_o), 32'(ig));
    chk({tag, "_dgnt"}, 32'(data_gnt_o), 32'(dg));
  endtask

  task automatic chk_rv(input string tag, input logic irv, input logic drv);
    chk({tag, "_irv"}, 32'(instr_rvalid_o), 32'(irv));
    chk({tag, "_drv"}, 32'(data_rvalid_o), 32'(drv));
  endtask

  initial begin
    // Reset held with every input active: all handshake outputs stay low.
    rst_ni = 1'b0;
    idle_inputs();
    instr_req_i  = 1'b1;
    data_req_i   = 1'b1;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    tick(); tick();
    chk("rst_mreq", 32'(mem_req_o), 32'd0);
    chk_gnt("rst", 1'b0, 1'b0);
    chk_rv("rst", 1'b0, 1'b0);
    chk("rst_outst", 32'(outstanding_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    idle_inputs();
    rst_ni = 1'b1;
    tick();

    // Round-robin with permanent grant: data, instr, data, instr.
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_1000;
    data_req_i   = 1'b1;
    data_addr_i  = 32'h0000_2000;
    data_be_i    = 4'h1;
    mem_gnt_i    = 1'b1;
    #1;
    chk_gnt("rr1", 1'b0, 1'b1);
    chk("rr1_addr", mem_addr_o, 32'h0000_2000);
    tick();
    mem_rvalid_i = 1'b1;
    #1;
    chk_gnt("rr2", 1'b1, 1'b0);
    chk("rr2_addr", mem_addr_o, 32'h0000_1000);
    chk("rr2_be", 32'(mem_be_o), 32'hF);
    chk_rv("rr2", 1'b0, 1'b1);
    chk("rr2_outst", 32'(outstanding_o), 32'd1);
    tick();
    #1;
    chk_gnt("rr3", 1'b0, 1'b1);
    chk_rv("rr3", 1'b1, 1'b0);
    tick();
    #1;
    chk_gnt("rr4", 1'b1, 1'b0);
    chk_rv("rr4", 1'b0, 1'b1);
    chk("rr4_outst", 32'(outstanding_o), 32'd1);
    tick();
    idle_inputs();
    mem_rvalid_i = 1'b1;
    #1;
    chk_rv("rr_drain", 1'b1, 1'b0);
    chk("rr_drain_mreq", 32'(mem_req_o), 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("rr_empty", 32'(outstanding_o), 32'd0);

    // Stalled data request stays on the bus while instr joins.
    data_req_i  = 1'b1;
    data_addr_i = 32'h0000_0100;
    data_be_i   = 4'hC;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lock_mreq", 32'(mem_req_o), 32'd1);
      chk("lock_addr", mem_addr_o, 32'h0000_0100);
      chk_gnt("lock_wait", 1'b0, 1'b0);
      tick();
    end
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0200;
    #1;
    chk("lock_join_addr", mem_addr_o, 32'h0000_0100);
    chk_gnt("lock_join", 1'b0, 1'b0);
    tick();
    mem_gnt_i = 1'b1;
    #1;
    chk("lock_gnt_addr", mem_addr_o, 32'h0000_0100);
    chk_gnt("lock_gnt", 1'b0, 1'b1);
    tick();
    data_req_i = 1'b0;
    #1;
    chk_gnt("lock_instr", 1'b1, 1'b0);
    chk("lock_instr_addr", mem_addr_o, 32'h0000_0200);
    chk("lock_instr_we", 32'(mem_we_o), 32'd0);
    tick();

    // FIFO full: request held off until a response frees a slot.
    #1;
    chk("full_outst", 32'(outstanding_o), 32'd2);
    chk("full_mreq", 32'(mem_req_o), 32'd0);
    chk_gnt("full", 1'b0, 1'b0);
    tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234_5678;
    #1;
    chk("full_pp_mreq", 32'(mem_req_o), 32'd1);
    chk_gnt("full_pp", 1'b1, 1'b0);
    chk_rv("full_pp", 1'b0, 1'b1);
    tick();
    chk("full_pp_outst", 32'(outstanding_o), 32'd2);
    instr_req_i = 1'b0;
    mem_gnt_i   = 1'b0;
    #1;
    chk_rv("full_d1", 1'b1, 1'b0);
    tick();
    #1;
    chk_rv("full_d2", 1'b1, 1'b0);
    tick();
    idle_inputs();
    #1;
    chk("full_empty", 32'(outstanding_o), 32'd0);

    // In-order response routing with store fields passed through.
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0400;
    mem_gnt_i    = 1'b1;
    #1;
    chk_gnt("ord_i", 1'b1, 1'b0);
    tick();
    instr_req_i  = 1'b0;
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'h3;
    data_addr_i  = 32'h0000_0300;
    data_wdata_i = 32'hDEAD_BEEF;
    #1;
    chk_gnt("ord_d", 1'b0, 1'b1);
    chk("ord_we", 32'(mem_we_o), 32'd1);
    chk("ord_be", 32'(mem_be_o), 32'h3);
    chk("ord_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    tick();
    idle_inputs();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hAAAA_0000;
    #1;
    chk_rv("ord_r1", 1'b1, 1'b0);
    chk("ord_r1_data", instr_rdata_o, 32'hAAAA_0000);
    tick();
    mem_rdata_i = 32'h5555_FFFF;
    #1;
    chk_rv("ord_r2", 1'b0, 1'b1);
    chk("ord_r2_data", data_rdata_o, 32'h5555_FFFF);
    tick();
    idle_inputs();
    #1;
    chk("ord_err", 32'(err_o), 32'd0);

    // Response with nothing outstanding.
    mem_rvalid_i = 1'b1;
    #1;
    chk_rv("spur", 1'b0, 1'b0);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    chk("spur_err", 32'(err_o), 32'd1);
    chk("spur_outst", 32'(outstanding_o), 32'd0);
    tick(); tick();
    chk("spur_sticky", 32'(err_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("spur_rst_err", 32'(err_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Asynchronous reset mid-transaction, then a late response.
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0500;
    mem_gnt_i    = 1'b1;
    tick();
    #1;
    chk("arst_pre_outst", 32'(outstanding_o), 32'd1);
    chk("arst_pre_mreq", 32'(mem_req_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_mreq", 32'(mem_req_o), 32'd0);
    chk_gnt("arst", 1'b0, 1'b0);
    chk("arst_outst", 32'(outstanding_o), 32'd0);
    tick();
    idle_inputs();
    rst_ni = 1'b1;
    tick();
    mem_rvalid_i = 1'b1;
    #1;
    chk_rv("late", 1'b0, 1'b0);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    chk("late_err", 32'(err_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
